// File: rtl/uart_rx_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receiver, 8 data bits LSB first, optional parity, 1 stop bit.
//            Stop-bit checking and BREAK recovery built when
//            UART_RX_FRAME_ERR_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx_ctrl #(
  parameter int baud  = 115200,
  parameter int check = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_de,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [15:0] c_baud_end = (baud == 921600) ? 16'd108 :
                                       (baud == 460800) ? 16'd217 :
                                       (baud == 230400) ? 16'd434 : 16'd868;
  localparam logic [15:0] c_baud_mid = (baud == 921600) ? 16'd54  :
                                       (baud == 460800) ? 16'd108 :
                                       (baud == 230400) ? 16'd217 : 16'd434;
  localparam logic [15:0] c_cnt_last   = c_baud_end - 16'd1;
  localparam logic [15:0] c_cnt_sample = c_baud_mid - 16'd1;
  localparam logic        c_par_en     = (check != 0);
  localparam logic        c_par_odd    = (check == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_RX_FRAME_ERR_EN
    STOP   = 3'd4,
    BREAK  = 3'd5
`else
    STOP   = 3'd4
`endif
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  logic [7:0]  r_rx_data;
  logic        r_rx_de;
  logic        r_parity_err;

  logic        w_fall;
  logic        w_sample;
  logic        w_par_exp;
  logic        w_par_bad;

  assign w_fall    = r_prev & ~r_sync2;
  assign w_sample  = (r_baud_cnt == c_cnt_sample);
  assign w_par_exp = c_par_odd ? ~(^r_shift) : (^r_shift);
  assign w_par_bad = c_par_en & (r_par_bit != w_par_exp);

  assign rx_data    = r_rx_data;
  assign rx_de      = r_rx_de;
  assign parity_err = r_parity_err;

`ifdef UART_RX_FRAME_ERR_EN
  logic r_frame_err;
  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  // Reset to 1 so an idle line never looks like a start edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_baud_cnt   <= 16'd0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_par_bit    <= 1'b0;
      r_rx_data    <= 8'd0;
      r_rx_de      <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err  <= 1'b0;
`endif
    end else begin
      r_rx_de      <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err  <= 1'b0;
`endif

      if (r_state == IDLE || r_baud_cnt == c_cnt_last) begin
        r_baud_cnt <= 16'd0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end

      case (r_state)
        IDLE: begin
          r_bit_cnt <= 3'd0;
          if (w_fall) begin
            r_state <= START;
          end
        end
        START: begin
          // A line back high at mid start bit was noise, not a frame.
          if (w_sample) begin
            r_state <= r_sync2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_sample) begin
            r_shift[r_bit_cnt] <= r_sync2;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= c_par_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (w_sample) begin
            r_par_bit <= r_sync2;
            r_state   <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next start edge.
          if (w_sample) begin
            r_state <= IDLE;
`ifdef UART_RX_FRAME_ERR_EN
            if (!r_sync2) begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end else begin
`else
            begin
`endif
              r_rx_data    <= r_shift;
              r_rx_de      <= 1'b1;
              r_parity_err <= w_par_bad;
            end
          end
        end
`ifdef UART_RX_FRAME_ERR_EN
        BREAK: begin
          if (r_sync2) begin
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
